// File: rtl/duty_sweep_gen.sv
// rtl/duty_sweep_gen.sv - Duty-cycle sweep generator driving the PWM stage duty input
// Steps the duty word on PWM period boundaries with hold, saturating, triangle and sawtooth profiles.
module duty_sweep_gen #(
  parameter int WIDTH        = 32,
  parameter int PERIOD       = 100,
  parameter int HOLD_PERIODS = 4,
  parameter int STEP         = 1,
  parameter int MAX_DUTY     = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_duty,
  output logic [WIDTH-1:0] DutyOut,
  output logic             period_tick,
  output logic             at_max,
  output logic             at_min
);

  localparam int PW = $clog2(PERIOD);
  localparam int HW = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;

  localparam logic [PW-1:0]    PCNT_LAST = PW'(PERIOD - 1);
  localparam logic [PW-1:0]    PCNT_ONE  = PW'(1);
  localparam logic [HW-1:0]    HCNT_LAST = HW'(HOLD_PERIODS - 1);
  localparam logic [HW-1:0]    HCNT_ONE  = HW'(1);
  localparam logic [WIDTH:0]   MAX_X     = (WIDTH + 1)'(MAX_DUTY);
  localparam logic [WIDTH:0]   STEP_X    = (WIDTH + 1)'(STEP);
  localparam logic [WIDTH-1:0] MAX_W     = WIDTH'(MAX_DUTY);
  localparam logic [WIDTH-1:0] STEP_W    = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] MAX_DN    = (MAX_DUTY >= STEP) ? WIDTH'(MAX_DUTY - STEP) : '0;
  localparam logic [WIDTH-1:0] STEP_MIN  = (STEP <= MAX_DUTY) ? STEP_W : MAX_W;

  localparam logic [1:0] M_HOLD = 2'b00;
  localparam logic [1:0] M_TRI  = 2'b10;
  localparam logic [1:0] M_SAW  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_UP   = 2'b01,
    ST_DOWN = 2'b10
  } state_t;

  state_t           state_q;
  logic [PW-1:0]    pcnt_q;
  logic [HW-1:0]    hcnt_q;
  logic [WIDTH-1:0] duty_q;
  logic             tick_q;

  logic [WIDTH:0]   sum_x;
  logic [WIDTH-1:0] inc_duty;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] upd_duty_d;
  state_t           upd_state_d;

  // Update result for the current state/mode; applied only on the update edge.
  always_comb begin
    sum_x        = {1'b0, duty_q} + STEP_X;
    inc_duty     = (sum_x > MAX_X) ? MAX_W : sum_x[WIDTH-1:0];
    load_clamped = (load_duty > MAX_W) ? MAX_W : load_duty;
    upd_duty_d   = duty_q;
    upd_state_d  = ST_UP;
    if (state_q == ST_DOWN && mode == M_TRI) begin
      if (duty_q == '0) begin
        upd_duty_d  = STEP_MIN;
        upd_state_d = ST_UP;
      end else begin
        upd_duty_d  = (duty_q >= STEP_W) ? duty_q - STEP_W : '0;
        upd_state_d = ST_DOWN;
      end
    end else if (duty_q == MAX_W) begin
      if (mode == M_TRI) begin
        upd_duty_d  = MAX_DN;
        upd_state_d = ST_DOWN;
      end else if (mode == M_SAW) begin
        upd_duty_d = '0;
      end
    end else if (mode != M_HOLD) begin
      upd_duty_d = inc_duty;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pcnt_q  <= '0;
      hcnt_q  <= '0;
      duty_q  <= '0;
      tick_q  <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          pcnt_q <= '0;
          hcnt_q <= '0;
          if (enable) begin
            state_q <= ST_UP;
          end
        end
        default: begin
          if (!enable) begin
            state_q <= ST_IDLE;
            pcnt_q  <= '0;
            hcnt_q  <= '0;
          end else if (pcnt_q == PCNT_LAST) begin
            pcnt_q <= '0;
            tick_q <= 1'b1;
            hcnt_q <= (hcnt_q == HCNT_LAST) ? '0 : hcnt_q + HCNT_ONE;
            if (hcnt_q == HCNT_LAST && !load) begin
              duty_q  <= upd_duty_d;
              state_q <= upd_state_d;
            end
          end else begin
            pcnt_q <= pcnt_q + PCNT_ONE;
          end
        end
      endcase
      // Preset wins over a coincident update and restarts the hold count.
      if (load) begin
        duty_q <= load_clamped;
        hcnt_q <= '0;
      end
    end
  end

  assign DutyOut     = duty_q;
  assign period_tick = tick_q;
  assign at_max      = (duty_q == MAX_W);
  assign at_min      = (duty_q == '0);

endmodule

// File: tb/tb_duty_sweep_gen.sv
// tb/tb_duty_sweep_gen.sv - Scoreboard bench for duty_sweep_gen
// Two instances cover the triangle test point and the hold/clamp/load/pause scenarios.
module tb_duty_sweep_gen;

  localparam int A_PERIOD = 10;
  localparam int A_HOLD   = 1;
  localparam int A_STEP   = 2;
  localparam int A_MAX    = 4;
  localparam int B_PERIOD = 6;
  localparam int B_HOLD   = 2;
  localparam int B_STEP   = 3;
  localparam int B_MAX    = 7;
  localparam int WATCHDOG = 2000;

  logic        clk;
  logic        rst_n_a, enable_a, load_a;
  logic [1:0]  mode_a;
  logic [31:0] load_duty_a, duty_a;
  logic        tick_a, at_max_a, at_min_a;
  logic        rst_n_b, enable_b, load_b;
  logic [1:0]  mode_b;
  logic [31:0] load_duty_b, duty_b;
  logic        tick_b, at_max_b, at_min_b;

  duty_sweep_gen #(
    .WIDTH(32), .PERIOD(A_PERIOD), .HOLD_PERIODS(A_HOLD), .STEP(A_STEP), .MAX_DUTY(A_MAX)
  ) dut_a (
    .clk(clk), .rst_n(rst_n_a), .enable(enable_a), .mode(mode_a), .load(load_a),
    .load_duty(load_duty_a), .DutyOut(duty_a), .period_tick(tick_a),
    .at_max(at_max_a), .at_min(at_min_a)
  );

  duty_sweep_gen #(
    .WIDTH(32), .PERIOD(B_PERIOD), .HOLD_PERIODS(B_HOLD), .STEP(B_STEP), .MAX_DUTY(B_MAX)
  ) dut_b (
    .clk(clk), .rst_n(rst_n_b), .enable(enable_b), .mode(mode_b), .load(load_b),
    .load_duty(load_duty_b), .DutyOut(duty_b), .period_tick(tick_b),
    .at_max(at_max_b), .at_min(at_min_b)
  );

  typedef struct {
    bit is_b;
    int duty;
    bit tick;
    bit amax;
    bit amin;
  } probe_t;

  int     tick_a_q[$];
  int     tick_b_q[$];
  probe_t probe_q[$];
  bit     done;

  int     n_vec;
  int     n_err;
  int     cyc;
  int     gap_a, gap_b;
  bit     seen_a, seen_b;
  int     e;
  probe_t p;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec = n_vec + 1;
    if (act != exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations on every tick and every pending probe.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (tick_a) begin
      if (tick_a_q.size() == 0) begin
        chk("a_tick_expected_depth", tick_a_q.size(), 1);
      end else begin
        e = tick_a_q.pop_front();
        chk("a_tick_duty", int'(duty_a), e);
        chk("a_tick_at_max", int'(at_max_a), int'(e == A_MAX));
        chk("a_tick_at_min", int'(at_min_a), int'(e == 0));
      end
    end
    if (tick_b) begin
      if (tick_b_q.size() == 0) begin
        chk("b_tick_expected_depth", tick_b_q.size(), 1);
      end else begin
        e = tick_b_q.pop_front();
        chk("b_tick_duty", int'(duty_b), e);
        chk("b_tick_at_max", int'(at_max_b), int'(e == B_MAX));
        chk("b_tick_at_min", int'(at_min_b), int'(e == 0));
      end
    end
    if (!rst_n_a || !enable_a) begin
      seen_a = 1'b0;
      gap_a  = 0;
    end else begin
      gap_a = gap_a + 1;
      if (tick_a) begin
        if (seen_a) chk("a_tick_spacing", gap_a, A_PERIOD);
        seen_a = 1'b1;
        gap_a  = 0;
      end
    end
    if (!rst_n_b || !enable_b) begin
      seen_b = 1'b0;
      gap_b  = 0;
    end else begin
      gap_b = gap_b + 1;
      if (tick_b) begin
        if (seen_b) chk("b_tick_spacing", gap_b, B_PERIOD);
        seen_b = 1'b1;
        gap_b  = 0;
      end
    end
    while (probe_q.size() > 0) begin
      p = probe_q.pop_front();
      if (p.is_b) begin
        chk("b_probe_duty", int'(duty_b), p.duty);
        chk("b_probe_tick", int'(tick_b), int'(p.tick));
        chk("b_probe_at_max", int'(at_max_b), int'(p.amax));
        chk("b_probe_at_min", int'(at_min_b), int'(p.amin));
      end else begin
        chk("a_probe_duty", int'(duty_a), p.duty);
        chk("a_probe_tick", int'(tick_a), int'(p.tick));
        chk("a_probe_at_max", int'(at_max_a), int'(p.amax));
        chk("a_probe_at_min", int'(at_min_a), int'(p.amin));
      end
    end
    if (done || cyc > WATCHDOG) begin
      if (!done) chk("watchdog_cycles", cyc, WATCHDOG);
      chk("a_pending_ticks", tick_a_q.size(), 0);
      chk("b_pending_ticks", tick_b_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic probe(input bit is_b, input int d, input bit t, input bit mx, input bit mn);
    probe_t q;
    q.is_b = is_b;
    q.duty = d;
    q.tick = t;
    q.amax = mx;
    q.amin = mn;
    probe_q.push_back(q);
  endtask

  task automatic exp_a(input int d, input int n);
    repeat (n) tick_a_q.push_back(d);
  endtask

  task automatic exp_b(input int d, input int n);
    repeat (n) tick_b_q.push_back(d);
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0; done = 1'b0;
    gap_a = 0; gap_b = 0; seen_a = 1'b0; seen_b = 1'b0;
    rst_n_a = 1'b0; enable_a = 1'b0; load_a = 1'b0; mode_a = 2'b10; load_duty_a = '0;
    rst_n_b = 1'b0; enable_b = 1'b0; load_b = 1'b0; mode_b = 2'b11; load_duty_b = '0;

    // Reset state on both instances.
    cycles(1);
    probe(0, 0, 0, 0, 1);
    probe(1, 0, 0, 0, 1);
    cycles(1);
    probe(0, 0, 0, 0, 1);

    // Triangle 0,2,4,2,0,2,4 with one step per tick.
    rst_n_a = 1'b1; enable_a = 1'b1;
    exp_a(2, 1); exp_a(4, 1); exp_a(2, 1); exp_a(0, 1); exp_a(2, 1); exp_a(4, 1);
    cycles(10);
    probe(0, 0, 0, 0, 1);
    cycles(1);
    probe(0, 2, 1, 0, 0);
    cycles(50);
    enable_a = 1'b0;
    cycles(1);
    probe(0, 4, 0, 1, 0);

    // Sawtooth with clamp: 0,3,6,7,0,3, two ticks per update.
    rst_n_b = 1'b1; enable_b = 1'b1; mode_b = 2'b11;
    exp_b(0, 1); exp_b(3, 2); exp_b(6, 2); exp_b(7, 2); exp_b(0, 2); exp_b(3, 1);
    cycles(61);

    // Saturating ramp to max, then five further updates pinned at 7.
    mode_b = 2'b01;
    exp_b(3, 1); exp_b(6, 2); exp_b(7, 11);
    cycles(84);

    // Preset then HOLD: value frozen while ticks continue.
    load_b = 1'b1; load_duty_b = 32'd5; mode_b = 2'b00;
    cycles(1);
    load_b = 1'b0;
    probe(1, 5, 0, 0, 0);
    exp_b(5, 4);
    cycles(23);

    // Sawtooth again; a clamped preset on the wrap-to-zero update edge wins.
    mode_b = 2'b11;
    exp_b(5, 1); exp_b(7, 4); exp_b(0, 1);
    cycles(23);
    load_b = 1'b1; load_duty_b = 32'd50;
    cycles(1);
    load_b = 1'b0;
    probe(1, 7, 1, 1, 0);
    cycles(12);

    // Triangle up to 7 then down to 4, pause mid-period in DOWN.
    mode_b = 2'b10;
    exp_b(0, 1); exp_b(3, 2); exp_b(6, 2); exp_b(7, 2); exp_b(4, 1);
    cycles(51);
    enable_b = 1'b0;
    cycles(5);
    probe(1, 4, 0, 0, 0);
    cycles(20);

    // Resume climbs from 4 (clamped to 7), then turns down again.
    enable_b = 1'b1;
    exp_b(4, 1); exp_b(7, 2); exp_b(4, 1);
    cycles(28);

    // Mid-run reset overrides enable.
    rst_n_b = 1'b0;
    cycles(1);
    probe(1, 0, 0, 0, 1);
    rst_n_b = 1'b1; enable_b = 1'b0;
    cycles(3);
    probe(1, 0, 0, 0, 1);
    cycles(1);
    done = 1'b1;
  end

endmodule

// File: doc/duty_sweep_gen.md
# duty_sweep_gen

Generates the duty-cycle word for the PWM stage, directly upstream of it. The PWM stage's duty input is driven from `DutyOut`. It runs a period counter matched to the PWM period and steps the duty value once every `HOLD_PERIODS` PWM periods, always on a period boundary. It supports hold, saturating ramp, triangle (breathing) and sawtooth profiles, plus a synchronous preset load.

## Interface
- `WIDTH`, 32: width of duty word and `load_duty`.
- `PERIOD`, 100: PWM period in `clk` cycles; must match the PWM stage; ≥2.
- `HOLD_PERIODS`, 4: PWM periods per duty step; ≥1.
- `STEP`, 1: duty increment/decrement per step; ≥1.
- `MAX_DUTY`, 100: upper duty limit; ≤ `PERIOD`.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset is synchronous and active-low.
- `enable` in 1: run counters and stepping; low = pause.
- `mode` in 2: 00 HOLD, 01 SAT, 10 TRI, 11 SAW.
- `load` in 1: preset request, one-cycle or level.
- `load_duty` in `WIDTH`: preset value.
- `DutyOut` out `WIDTH`: registered duty word to the PWM stage.
- `period_tick` out 1: one-cycle pulse at each PWM period wrap.
- `at_max` out 1: `DutyOut == MAX_DUTY`.
- `at_min` out 1: `DutyOut == 0`.

## Operation
- **Registers:**
  - `pcnt`: 0..`PERIOD-1`.
  - `hcnt`: 0..`HOLD_PERIODS-1`.
  - `state`: one of IDLE, UP, DOWN.
  - `DutyOut`.
  - `period_tick`.
- **Reset (`rst_n`=0 at an edge):**
  - `pcnt`=0, `hcnt`=0, `state`=IDLE, `DutyOut`=0, `period_tick`=0.
  - Therefore `at_min`=1 and `at_max`=0 (unless `MAX_DUTY`=0).
  - Reset overrides all other inputs.
- **IDLE:**
  - Counters are held at 0 and `DutyOut` is held.
  - `enable`=1 moves to UP at the next edge.
- **UP/DOWN, `enable`=0:** next state IDLE, `pcnt`/`hcnt` cleared, `DutyOut` retained, `period_tick`=0.
- **Period counter:**
  - In UP/DOWN, `pcnt` increments every cycle.
  - At `PERIOD-1` it wraps to 0, `period_tick` is set for the following cycle, and `hcnt` advances (wrapping at `HOLD_PERIODS-1`).
- **Update event:** occurs on the edge where `pcnt` wraps and `hcnt==HOLD_PERIODS-1`. On that edge:
  - UP, `DutyOut==MAX_DUTY`:
    - TRI: duty ← max(MAX−STEP, 0), state ← DOWN.
    - SAW: duty ← 0.
    - SAT/HOLD: unchanged.
  - UP, otherwise:
    - HOLD: unchanged.
    - Else: duty ← min(duty+STEP, MAX_DUTY).
  - DOWN, any mode other than TRI: state ← UP and the UP rule is applied in the same update.
  - DOWN + TRI, duty==0: duty ← min(STEP, MAX), state ← UP.
  - DOWN + TRI, else: duty ← max(duty−STEP, 0).
- **Arithmetic:**
  - Sums are computed in `WIDTH+1` bits and clamped to `MAX_DUTY`.
  - Subtraction is compare-before-subtract, so it never underflows.
- **Load:**
  - Priority: `load`=1 wins over an update on the same edge.
  - Effect: `DutyOut` ← min(`load_duty`, `MAX_DUTY`), `hcnt` ← 0, `state` unchanged.
  - `pcnt` is unaffected.
  - Load is honoured in IDLE as well.
- **Mode change:**
  - Sampled only at update events; there is no immediate effect on `DutyOut`.
- **Counter semantics:** `mode` does not alter counters. HOLD still produces ticks.

## Timing
- `DutyOut` changes only on an update or load edge. After an update it is visible in the same cycle as the corresponding `period_tick`=1, i.e. aligned to the first cycle of the new PWM period.
- First update after `enable` rises, when `enable` is asserted at edge E:
  - UP is entered at E+1.
  - The first wrap occurs `PERIOD` cycles later.
  - The first update lands `PERIOD`×`HOLD_PERIODS` cycles after E+1.
- `period_tick` is high for exactly one cycle per `PERIOD` cycles while running, and never in IDLE.
- Load latency is 1 cycle.
- `at_max`/`at_min` are decoded from the `DutyOut` register, so they have no extra latency.

## Test plan
- **Reset and tick spacing:** `rst_n`=0 for 2 cycles, then `enable`=1, with `PERIOD`=10, `HOLD_PERIODS`=1, STEP=2, MAX=4, mode=10.
  - `DutyOut`=0 during reset.
  - `period_tick` pulses every 10 cycles.
  - `DutyOut` sequence 0,2,4,2,0,2,4, one step per tick.
- **Sawtooth with clamp:** mode=11, STEP=3, MAX=7.
  - Sequence 0,3,6,7,0,3.
  - `at_max`=1 only while `DutyOut`=7.
- **SAT and HOLD:** run mode=01 to MAX.
  - `DutyOut` stays at 7 across 5 further updates.
  - Switching to mode=00 freezes any value while ticks continue.
- **Load priority:** assert `load`=1 with `load_duty`=50, MAX=7, on an update edge.
  - `DutyOut`=7 next cycle.
  - The next update occurs `HOLD_PERIODS` ticks later.
- **Pause and resume:** drop `enable` mid-period at `DutyOut`=4 in state DOWN.
  - `DutyOut` holds 4 and there are no ticks.
  - On re-enable, the first update is 4+STEP, clamped (UP direction).
  - Repeat with `rst_n`=0 mid-run: everything returns to reset values on the next edge.
